// File: rtl/router_out_arbiter.sv
// Round-robin, packet-granular arbiter that drains three router FIFOs onto one
// 8-bit egress channel through a 2-entry valid/ready output buffer.
module router_out_arbiter (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] vld_out,
    input  logic [2:0] soft_reset,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    output logic [2:0] read_enb,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic [2:0] grant,
    output logic       pkt_abort
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_BODY = 2'd2} state_t;

    state_t     state_r;
    logic [2:0] grant_r;
    logic [1:0] gidx_r;
    logic [1:0] last_grant_r;
    logic [6:0] rem_r;
    logic       pkt_abort_r;
    logic       inflight_r;
    logic       infl_sop_r;
    logic       infl_eop_r;
    logic [1:0] infl_port_r;
    logic [1:0] count_r;
    logic [7:0] head_data_r;
    logic       head_sop_r;
    logic       head_eop_r;
    logic [7:0] tail_data_r;
    logic       tail_sop_r;
    logic       tail_eop_r;

    logic       pop_s;
    logic       space_s;
    logic       push_s;
    logic       abort_s;
    logic       issue_s;
    logic       pick_valid_s;
    logic [1:0] p0_s;
    logic [1:0] p1_s;
    logic [1:0] p2_s;
    logic [1:0] pick_idx_s;
    logic [1:0] issue_idx_s;
    logic [2:0] cand_s;
    logic [7:0] in_byte_s;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

    // A read may issue only if the byte it returns is guaranteed a buffer slot
    assign pop_s   = (count_r != 2'd0) && out_ready;
    assign space_s = ({1'b0, count_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
    assign abort_s = (state_r != ST_IDLE) && soft_reset[gidx_r];
    assign push_s  = inflight_r && !abort_s;

    // Byte returned by the FIFO that was read last cycle
    always_comb begin
        in_byte_s = data_in0;
        case (infl_port_r)
            2'd1:    in_byte_s = data_in1;
            2'd2:    in_byte_s = data_in2;
            default: in_byte_s = data_in0;
        endcase
    end

    // Round-robin pick and combinational read strobe
    always_comb begin
        cand_s       = vld_out & ~soft_reset;
        p0_s         = next_port(last_grant_r);
        p1_s         = next_port(p0_s);
        p2_s         = next_port(p1_s);
        pick_valid_s = |cand_s;
        pick_idx_s   = cand_s[p0_s] ? p0_s : (cand_s[p1_s] ? p1_s : p2_s);
        issue_s      = 1'b0;
        issue_idx_s  = gidx_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s && space_s) begin
                    issue_s     = 1'b1;
                    issue_idx_s = pick_idx_s;
                end else begin
                    issue_s     = 1'b0;
                end
            end
            ST_BODY: begin
                if (vld_out[gidx_r] && !soft_reset[gidx_r] && space_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: issue_s = 1'b0;
        endcase
        read_enb = issue_s ? port_onehot(issue_idx_s) : 3'b000;
    end

    // Packet FSM: grant ownership, remaining-byte count and in-flight tagging
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_r      <= ST_IDLE;
            grant_r      <= 3'b000;
            gidx_r       <= 2'd0;
            last_grant_r <= 2'd2;
            rem_r        <= 7'd0;
            pkt_abort_r  <= 1'b0;
            inflight_r   <= 1'b0;
            infl_sop_r   <= 1'b0;
            infl_eop_r   <= 1'b0;
            infl_port_r  <= 2'd0;
        end else begin
            pkt_abort_r <= abort_s;
            inflight_r  <= issue_s;
            infl_port_r <= issue_idx_s;
            infl_sop_r  <= (state_r == ST_IDLE);
            infl_eop_r  <= (state_r == ST_BODY) && (rem_r == 7'd1);
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        grant_r <= port_onehot(pick_idx_s);
                        gidx_r  <= pick_idx_s;
                        state_r <= ST_HDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    last_grant_r <= gidx_r;
                    if (abort_s) begin
                        grant_r <= 3'b000;
                        state_r <= ST_IDLE;
                    end else begin
                        rem_r   <= {1'b0, in_byte_s[7:2]} + 7'd1;
                        state_r <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (abort_s) begin
                        last_grant_r <= gidx_r;
                        grant_r      <= 3'b000;
                        state_r      <= ST_IDLE;
                    end else if (issue_s) begin
                        rem_r <= rem_r - 7'd1;
                        if (rem_r == 7'd1) begin
                            grant_r <= 3'b000;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_BODY;
                        end
                    end else begin
                        state_r <= ST_BODY;
                    end
                end
                default: begin
                    grant_r <= 3'b000;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer; the head entry drives the egress port
    always_ff @(posedge clk) begin
        if (resetn) begin
            count_r     <= 2'd0;
            head_data_r <= 8'h00;
            head_sop_r  <= 1'b0;
            head_eop_r  <= 1'b0;
            tail_data_r <= 8'h00;
            tail_sop_r  <= 1'b0;
            tail_eop_r  <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_data_r <= in_byte_s;
                        head_sop_r  <= infl_sop_r;
                        head_eop_r  <= infl_eop_r;
                    end else begin
                        tail_data_r <= in_byte_s;
                        tail_sop_r  <= infl_sop_r;
                        tail_eop_r  <= infl_eop_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_data_r <= tail_data_r;
                    head_sop_r  <= tail_sop_r;
                    head_eop_r  <= tail_eop_r;
                    count_r     <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_data_r <= in_byte_s;
                        head_sop_r  <= infl_sop_r;
                        head_eop_r  <= infl_eop_r;
                    end else begin
                        head_data_r <= tail_data_r;
                        head_sop_r  <= tail_sop_r;
                        head_eop_r  <= tail_eop_r;
                        tail_data_r <= in_byte_s;
                        tail_sop_r  <= infl_sop_r;
                        tail_eop_r  <= infl_eop_r;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_data_r;
    assign out_sop   = head_sop_r;
    assign out_eop   = head_eop_r;
    assign grant     = grant_r;
    assign pkt_abort = pkt_abort_r;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: behavioural FIFOs feed the arbiter and
// a negedge monitor logs the egress stream for per-scenario checks.
module tb_router_out_arbiter;
    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [2:0] vld_out;
    logic [2:0] soft_reset = 3'b000;
    logic [7:0] data_in0 = 8'h00;
    logic [7:0] data_in1 = 8'h00;
    logic [7:0] data_in2 = 8'h00;
    logic [2:0] read_enb;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic [2:0] grant;
    logic       pkt_abort;

    int total = 0;
    int bad = 0;

    router_out_arbiter dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .soft_reset(soft_reset),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
        .read_enb(read_enb), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .grant(grant), .pkt_abort(pkt_abort)
    );

    always #5 clk = ~clk;

    // Behavioural FIFOs: dataout is registered, valid the cycle after read_enb
    logic [7:0] mem [3][256];
    int         wr [3] = '{0, 0, 0};
    int         rd [3] = '{0, 0, 0};
    logic [2:0] en = 3'b111;

    assign vld_out[0] = en[0] && (wr[0] != rd[0]);
    assign vld_out[1] = en[1] && (wr[1] != rd[1]);
    assign vld_out[2] = en[2] && (wr[2] != rd[2]);

    always @(posedge clk) begin
        if (read_enb[0]) begin data_in0 <= mem[0][rd[0] & 255]; rd[0] <= rd[0] + 1; end
        if (read_enb[1]) begin data_in1 <= mem[1][rd[1] & 255]; rd[1] <= rd[1] + 1; end
        if (read_enb[2]) begin data_in2 <= mem[2][rd[2] & 255]; rd[2] <= rd[2] + 1; end
    end

    // Egress monitor
    logic [7:0] ob_data [512];
    logic       ob_sop [512];
    logic       ob_eop [512];
    int         n = 0;
    int         rd_cnt [3] = '{0, 0, 0};
    int         stall_err = 0;
    int         onehot_err = 0;
    logic       stall_prev = 1'b0;
    logic [9:0] prev_out = 10'd0;

    always @(negedge clk) begin
        if (stall_prev && (!out_valid || ({out_data, out_sop, out_eop} != prev_out)))
            stall_err <= stall_err + 1;
        stall_prev <= out_valid && !out_ready;
        prev_out   <= {out_data, out_sop, out_eop};
        if (out_valid && out_ready) begin
            ob_data[n & 511] <= out_data;
            ob_sop[n & 511]  <= out_sop;
            ob_eop[n & 511]  <= out_eop;
            n <= n + 1;
        end
        if ($countones(read_enb) > 1) onehot_err <= onehot_err + 1;
        if (read_enb[0]) rd_cnt[0] <= rd_cnt[0] + 1;
        if (read_enb[1]) rd_cnt[1] <= rd_cnt[1] + 1;
        if (read_enb[2]) rd_cnt[2] <= rd_cnt[2] + 1;
    end

    task automatic push_byte(input int p, input logic [7:0] b);
        mem[p][wr[p] & 255] = b;
        wr[p] = wr[p] + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int p = 0; p < 3; p++) wr[p] = rd[p];
        en = 3'b111;
        soft_reset = 3'b000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant); end
        total++; if (read_enb !== 3'b000) begin bad++; $display("FAIL reset_read_enb got=%b exp=000", read_enb); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (out_sop !== 1'b0) begin bad++; $display("FAIL reset_out_sop got=%b exp=0", out_sop); end
        total++; if (out_eop !== 1'b0) begin bad++; $display("FAIL reset_out_eop got=%b exp=0", out_eop); end
        total++; if (pkt_abort !== 1'b0) begin bad++; $display("FAIL reset_pkt_abort got=%b exp=0", pkt_abort); end
        @(posedge clk); #1;
        resetn = 1'b0;
    endtask

    task automatic test_single();
        logic [2:0] exp_re [10];
        logic [2:0] exp_gr [10];
        logic       exp_ov [10];
        logic [7:0] exp_d  [10];
        int base;
        exp_re = '{3'b010, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        exp_gr = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        exp_ov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_d  = '{8'h00, 8'h00, 8'h0D, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h5C, 8'h00, 8'h00};
        do_reset();
        base = n;
        @(posedge clk); #1;
        push_byte(1, 8'h0D); push_byte(1, 8'hA1); push_byte(1, 8'hA2);
        push_byte(1, 8'hA3); push_byte(1, 8'h5C);
        for (int c = 0; c < 10; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            @(negedge clk);
            total++; if (read_enb !== exp_re[c]) begin bad++; $display("FAIL single_read_enb c=%0d got=%b exp=%b", c, read_enb, exp_re[c]); end
            total++; if (grant !== exp_gr[c]) begin bad++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, grant, exp_gr[c]); end
            total++; if (out_valid !== exp_ov[c]) begin bad++; $display("FAIL single_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov[c]); end
            if (exp_ov[c]) begin
                total++;
                if ({out_data, out_sop, out_eop} !== {exp_d[c], c == 2, c == 7}) begin
                    bad++;
                    $display("FAIL single_byte c=%0d got=%h/%b/%b exp=%h/%b/%b", c, out_data, out_sop, out_eop, exp_d[c], c == 2, c == 7);
                end
            end
        end
        @(posedge clk); #1;
        total++; if (n - base !== 5) begin bad++; $display("FAIL single_count got=%0d exp=5", n - base); end
    endtask

    task automatic test_rr();
        logic [2:0] order [8];
        logic [7:0] exp_d [8];
        logic [2:0] prev_g;
        int k;
        int base;
        exp_d = '{8'h00, 8'hE0, 8'h01, 8'hE1, 8'h02, 8'hE2, 8'h00, 8'hF0};
        do_reset();
        base = n;
        k = 0;
        prev_g = 3'b000;
        @(posedge clk); #1;
        push_byte(0, 8'h00); push_byte(0, 8'hE0); push_byte(0, 8'h00); push_byte(0, 8'hF0);
        push_byte(1, 8'h01); push_byte(1, 8'hE1);
        push_byte(2, 8'h02); push_byte(2, 8'hE2);
        for (int c = 0; c < 30; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (grant != 3'b000 && grant != prev_g && k < 8) begin
                order[k] = grant;
                k++;
            end
            prev_g = grant;
        end
        total++; if (k !== 4) begin bad++; $display("FAIL rr_grant_count got=%0d exp=4", k); end
        total++; if (order[0] !== 3'b001) begin bad++; $display("FAIL rr_order0 got=%b exp=001", order[0]); end
        total++; if (order[1] !== 3'b010) begin bad++; $display("FAIL rr_order1 got=%b exp=010", order[1]); end
        total++; if (order[2] !== 3'b100) begin bad++; $display("FAIL rr_order2 got=%b exp=100", order[2]); end
        total++; if (order[3] !== 3'b001) begin bad++; $display("FAIL rr_order3 got=%b exp=001", order[3]); end
        @(posedge clk); #1;
        total++; if (n - base !== 8) begin bad++; $display("FAIL rr_bytes got=%0d exp=8", n - base); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({ob_data[base + i], ob_sop[base + i], ob_eop[base + i]} !== {exp_d[i], (i % 2) == 0, (i % 2) == 1}) begin
                bad++;
                $display("FAIL rr_stream i=%0d got=%h/%b/%b exp=%h/%b/%b", i, ob_data[base + i], ob_sop[base + i], ob_eop[base + i], exp_d[i], (i % 2) == 0, (i % 2) == 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       pat [4];
        logic [7:0] exp_b;
        int base;
        int serr0;
        int c;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        base = n;
        serr0 = stall_err;
        @(posedge clk); #1;
        push_byte(0, 8'hFC);
        for (int i = 1; i <= 63; i++) push_byte(0, 8'(i));
        push_byte(0, 8'hAA);
        c = 0;
        while ((n - base) < 65 && c < 600) begin
            @(posedge clk); #1;
            out_ready = pat[c % 4];
            c++;
        end
        if (c >= 600) begin bad++; total++; $display("FAIL bp_timeout got=%0d exp=65 bytes", n - base); end
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++; if (n - base !== 65) begin bad++; $display("FAIL bp_bytes got=%0d exp=65", n - base); end
        total++; if (stall_err !== serr0) begin bad++; $display("FAIL bp_stall_stable got=%0d exp=%0d", stall_err, serr0); end
        for (int i = 0; i < 65; i++) begin
            exp_b = (i == 0) ? 8'hFC : ((i == 64) ? 8'hAA : 8'(i));
            total++;
            if ({ob_data[base + i], ob_sop[base + i], ob_eop[base + i]} !== {exp_b, i == 0, i == 64}) begin
                bad++;
                $display("FAIL bp_stream i=%0d got=%h/%b/%b exp=%h/%b/%b", i, ob_data[base + i], ob_sop[base + i], ob_eop[base + i], exp_b, i == 0, i == 64);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_b;
        int base;
        do_reset();
        base = n;
        @(posedge clk); #1;
        for (int c = 0; c < 30; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            if (c == 0) begin
                push_byte(2, 8'h52);
                for (int i = 1; i <= 20; i++) push_byte(2, 8'h30 + 8'(i));
                push_byte(2, 8'h99);
            end
            if (c == 13) begin soft_reset = 3'b100; wr[2] = rd[2]; end
            if (c == 14) soft_reset = 3'b000;
            if (c == 15) begin push_byte(0, 8'h04); push_byte(0, 8'h77); push_byte(0, 8'h88); end
            @(negedge clk);
            if (c == 13) begin
                total++; if (read_enb !== 3'b000) begin bad++; $display("FAIL abort_read_enb got=%b exp=000", read_enb); end
                total++; if (grant !== 3'b100) begin bad++; $display("FAIL abort_grant_before got=%b exp=100", grant); end
            end
            if (c == 14) begin
                total++; if (pkt_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", pkt_abort); end
                total++; if (grant !== 3'b000) begin bad++; $display("FAIL abort_grant_after got=%b exp=000", grant); end
            end
            if (c == 15) begin
                total++; if (pkt_abort !== 1'b0) begin bad++; $display("FAIL abort_pulse_width got=%b exp=0", pkt_abort); end
            end
        end
        @(posedge clk); #1;
        total++; if (n - base !== 14) begin bad++; $display("FAIL abort_bytes got=%0d exp=14", n - base); end
        for (int i = 0; i < 14; i++) begin
            exp_b = (i == 0) ? 8'h52 : (i <= 10) ? 8'h30 + 8'(i) : (i == 11) ? 8'h04 : (i == 12) ? 8'h77 : 8'h88;
            total++;
            if ({ob_data[base + i], ob_sop[base + i], ob_eop[base + i]} !== {exp_b, i == 0 || i == 11, i == 13}) begin
                bad++;
                $display("FAIL abort_stream i=%0d got=%h/%b/%b exp=%h/%b/%b", i, ob_data[base + i], ob_sop[base + i], ob_eop[base + i], exp_b, i == 0 || i == 11, i == 13);
            end
        end
    endtask

    task automatic test_gap();
        logic [7:0] exp_b;
        int base;
        int rbase;
        do_reset();
        base = n;
        rbase = rd_cnt[0];
        @(posedge clk); #1;
        for (int c = 0; c < 25; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            if (c == 0) begin
                push_byte(0, 8'h20);
                for (int i = 1; i <= 8; i++) push_byte(0, 8'h40 + 8'(i));
                push_byte(0, 8'h55);
            end
            if (c == 4) en = 3'b110;
            if (c == 9) en = 3'b111;
            @(negedge clk);
            if (c >= 4 && c <= 8) begin
                total++; if (read_enb !== 3'b000) begin bad++; $display("FAIL gap_read_enb c=%0d got=%b exp=000", c, read_enb); end
                total++; if (grant !== 3'b001) begin bad++; $display("FAIL gap_grant c=%0d got=%b exp=001", c, grant); end
            end
            if (c == 16) begin
                total++; if (grant !== 3'b000) begin bad++; $display("FAIL gap_grant_release got=%b exp=000", grant); end
            end
        end
        @(posedge clk); #1;
        total++; if (rd_cnt[0] - rbase !== 10) begin bad++; $display("FAIL gap_reads got=%0d exp=10", rd_cnt[0] - rbase); end
        total++; if (n - base !== 10) begin bad++; $display("FAIL gap_bytes got=%0d exp=10", n - base); end
        for (int i = 0; i < 10; i++) begin
            exp_b = (i == 0) ? 8'h20 : (i == 9) ? 8'h55 : 8'h40 + 8'(i);
            total++;
            if ({ob_data[base + i], ob_sop[base + i], ob_eop[base + i]} !== {exp_b, i == 0, i == 9}) begin
                bad++;
                $display("FAIL gap_stream i=%0d got=%h/%b/%b exp=%h/%b/%b", i, ob_data[base + i], ob_sop[base + i], ob_eop[base + i], exp_b, i == 0, i == 9);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            if (c == 0) begin
                push_byte(1, 8'h29);
                for (int i = 1; i <= 10; i++) push_byte(1, 8'h60 + 8'(i));
                push_byte(1, 8'h6F);
            end
            if (c == 5) begin
                resetn = 1'b1;
                en = 3'b000;
                push_byte(0, 8'h00); push_byte(0, 8'h01);
                push_byte(2, 8'h02); push_byte(2, 8'h03);
            end
            if (c == 6) resetn = 1'b0;
            if (c == 7) en = 3'b111;
            @(negedge clk);
            if (c == 5) begin
                total++; if (grant !== 3'b010) begin bad++; $display("FAIL rstmid_grant_before got=%b exp=010", grant); end
            end
            if (c == 6) begin
                total++; if (grant !== 3'b000) begin bad++; $display("FAIL rstmid_grant got=%b exp=000", grant); end
                total++; if (read_enb !== 3'b000) begin bad++; $display("FAIL rstmid_read_enb got=%b exp=000", read_enb); end
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
                total++; if ({out_data, out_sop, out_eop} !== 10'd0) begin bad++; $display("FAIL rstmid_out_bytes got=%h/%b/%b exp=00/0/0", out_data, out_sop, out_eop); end
                total++; if (pkt_abort !== 1'b0) begin bad++; $display("FAIL rstmid_pkt_abort got=%b exp=0", pkt_abort); end
            end
            if (c == 7) begin
                total++; if (read_enb !== 3'b001) begin bad++; $display("FAIL rstmid_first_pick got=%b exp=001", read_enb); end
            end
            if (c == 8) begin
                total++; if (grant !== 3'b001) begin bad++; $display("FAIL rstmid_grant_after got=%b exp=001", grant); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_abort();
        test_gap();
        test_reset_mid();
        @(posedge clk); #1;
        total++; if (onehot_err !== 0) begin bad++; $display("FAIL read_enb_onehot got=%0d exp=0", onehot_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Packet-granular round-robin arbiter that drains the three router output FIFOs onto one shared 8-bit egress channel. It watches each FIFO's `vld_out` and grants one port at a time. It issues `read_enb` pulses to the granted FIFO, parses the header length, and holds the grant until the parity byte has been read. Bytes pass through a 2-entry output buffer with a valid/ready handshake. It sits between the `router_fifo` instances / `router_sync` and the downstream consumer.

## Interface
- No parameters. Packet format is fixed: header `[7:2]` = payload length (0..63), `[1:0]` = address, followed by the payload bytes, then 1 parity byte.
- `clk` in 1: the single clock; all state is updated on its rising edge.
- `resetn` in 1: synchronous reset, active-high.
- `vld_out` in 3: per-port FIFO not-empty.
- `soft_reset` in 3: per-port FIFO flush from `router_sync`.
- `data_in0`, `data_in1`, `data_in2` in 8 each: FIFO `dataout`, valid the cycle after that port's `read_enb`.
- `read_enb` out 3: one-hot FIFO read strobe.
- `out_ready` in 1: downstream accepts a byte.
- `out_valid` out 1: `out_data` holds a byte.
- `out_data` out 8: egress byte.
- `out_sop` out 1: marks the header byte, qualified by `out_valid`.
- `out_eop` out 1: marks the parity byte, qualified by `out_valid`.
- `grant` out 3: one-hot owner of the channel; 0 when idle.
- `pkt_abort` out 1: one-cycle pulse when the granted packet is abandoned.

## Operation
- **States:** IDLE, HDR, BODY.
- **IDLE:**
  - If any `vld_out` bit is set and the buffer has space, pick a port by round-robin, searching from `last_grant+1` mod 3.
  - Set `grant` to that port and pulse `read_enb` for it.
  - Set the in-flight flag with tag sop, then go to HDR.
- **HDR** (header is on `data_in[g]` this cycle):
  - Push the header into the buffer with sop.
  - Load `rem = hdr[7:2] + 1` (7-bit, range 1..64).
  - Set `last_grant = g`, then go to BODY.
  - No read is issued in HDR (one bubble per packet).
- **BODY:**
  - Each cycle with `vld_out[g]` and space: pulse `read_enb[g]` and decrement `rem`.
  - The read issued when `rem==1` is tagged eop.
  - After issuing it, `grant` goes to 0 and the state goes to IDLE.
  - If `vld_out[g]` is low, stall with no read; the grant is held.
- **Buffer space:**
  - Space means `count + inflight - pop < 2`, where `pop = out_valid & out_ready`.
  - `count` is the number of buffered bytes (0..2); `inflight` is 0 or 1.
  - The in-flight byte is always written at the next edge, with its sop/eop tag.
- **Read strobe:** `read_enb` is combinational from the registered state, `vld_out`, `soft_reset` and buffer space. At most one bit is set. It is never set in HDR or when `soft_reset[g]` is high.
- **Abort:**
  - Trigger: `soft_reset[g]` high while in HDR or BODY.
  - Go to IDLE, clear `grant`, and discard any in-flight byte (no buffer write).
  - Pulse `pkt_abort` the next cycle.
  - Bytes already buffered still drain; no eop is emitted for that packet.
  - `last_grant` is updated to `g`.
- **Buffer:** 2-entry FIFO of {data, sop, eop}; `out_*` present the head entry.
- **Boundaries:**
  - A zero-length header gives `rem=1`: header then parity, 2 bytes total.
  - A 63-byte payload gives 65 bytes total.
  - The next packet's header read may be issued in IDLE while the previous tail is still buffered.
  - Ports starved longer than a long packet are flushed by `router_sync`'s timeout; that is accepted system behaviour.

## Timing
- **Reset values:** state IDLE, `grant=0`, `read_enb=0`, `out_valid=0`, `out_data=0`, `out_sop=0`, `out_eop=0`, `pkt_abort=0`, `count=0`, `inflight=0`, `last_grant=2` (so port 0 wins first).
- **Read latency:** a `read_enb` in cycle t puts the byte on `data_in` in t+1; it is buffered at the end of t+1 and `out_valid` rises in t+2.
- **Throughput:**
  - 1 byte/cycle in BODY with `out_ready=1`.
  - Per packet, `len+2` bytes take `len+3` issue cycles.
- **Handshake:** `out_data`, `out_sop` and `out_eop` hold stable while `out_valid & !out_ready`.
- **Reset mid-packet:** everything returns to reset values at the next edge, and the buffer is cleared.

## Test plan
- **Single packet:** port 1 has header 0x0D (len 3, addr 1) plus 3 payload bytes and parity, with `out_ready=1`.
  - Expect `grant=3'b010` and 5 `read_enb[1]` pulses, with a bubble after the first.
  - Expect 5 bytes on `out_data`: sop on 0x0D, eop on parity, header `out_valid` 2 cycles after the first read.
- **Round-robin fairness:** all three ports hold 2-byte packets (len 0) from reset.
  - Expect grant order 0, 1, 2, 0.
  - Expect no interleaving of bytes between packets.
- **Backpressure:** 63-byte payload with `out_ready` toggling 1,0,0,1.
  - `count` never exceeds 2 and no byte is lost or duplicated.
  - `out_data` stays stable during stalls.
- **Abort:** assert `soft_reset[2]` in BODY of port 2 with `rem=10`.
  - Expect `pkt_abort` for 1 cycle and `grant` back to 0.
  - No eop for the aborted packet; the next packet from port 0 starts with sop.
- **Empty mid-packet:** drop `vld_out[0]` for 5 cycles during BODY.
  - No `read_enb` during the gap and `grant` held at `3'b001`.
  - Reads resume and total bytes match `len+2`.
- **Reset mid-packet:** assert `resetn` for 1 cycle during BODY.
  - All outputs return to reset values at the next edge.
  - Port 0 wins the next arbitration.
